row_pingpong_buffer: RTL and testbench

Parametrised, single-clock, double-banked (ping-pong) row buffer for the video pipeline. A producer (rasteriser or SDRAM fetch) fills the back bank with byte-enabled writes and commits it. The display scan-out reads the front bank and requests a swap at each line start. Overrun and underrun are tracked with sticky status flags, and an underrun repeats the previous row instead of emitting garbage.

---
 rtl/row_pingpong_buffer.sv | 106 ++++++++++
 tb/tb_row_pingpong_buffer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/row_pingpong_buffer.sv
// Double-banked row buffer: the producer fills and commits the back bank while
// scan-out reads the front bank; a line-start swap exchanges them.
module row_pingpong_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 80,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic                  renable,
  output logic [DATA_W-1:0]     rdata,
  input  logic                  rswap,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  wenable,
  input  logic                  wcommit,
  input  logic                  clr_flags,
  output logic                  back_full,
  output logic                  front_valid,
  output logic                  wovf,
  output logic                  rund
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic              front_sel;
  logic              front_sel_nxt;
  logic              back_full_nxt;
  logic              front_valid_nxt;
  logic              wovf_nxt;
  logic              rund_nxt;

  logic              w_in_range;
  logic              r_in_range;
  logic              wr_fire;
  logic              swap_ok;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] rd_word;

  assign w_in_range = {1'b0, waddr} < DEPTH_L;
  assign r_in_range = {1'b0, raddr} < DEPTH_L;
  assign widx       = waddr[IDX_W-1:0];
  assign ridx       = raddr[IDX_W-1:0];
  assign wr_fire    = wenable && !back_full && w_in_range;
  assign swap_ok    = rswap && back_full;
  assign rd_word    = front_sel ? bank1[ridx] : bank0[ridx];

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    front_sel_nxt   = front_sel;
    back_full_nxt   = back_full;
    front_valid_nxt = front_valid;
    wovf_nxt        = wovf && !clr_flags;
    rund_nxt        = rund && !clr_flags;

    if (swap_ok) begin
      front_sel_nxt   = !front_sel;
      back_full_nxt   = 1'b0;
      front_valid_nxt = 1'b1;
    end else if (wcommit && !back_full) begin
      back_full_nxt = 1'b1;
    end

    // Setting events override a same-cycle clear.
    if ((wenable || wcommit) && back_full) wovf_nxt = 1'b1;
    if (rswap && !back_full)               rund_nxt = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel   <= 1'b0;
      back_full   <= 1'b0;
      front_valid <= 1'b0;
      wovf        <= 1'b0;
      rund        <= 1'b0;
      rdata       <= '0;
    end else begin
      front_sel   <= front_sel_nxt;
      back_full   <= back_full_nxt;
      front_valid <= front_valid_nxt;
      wovf        <= wovf_nxt;
      rund        <= rund_nxt;
      if (renable) rdata <= r_in_range ? rd_word : '0;
    end
  end

  // NOTE: storage has no reset; a reset only invalidates it logically via the control flags.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_fire && wbe[b]) begin
        if (front_sel) bank0[widx][8*b +: 8] <= wdata[8*b +: 8];
        else           bank1[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_row_pingpong_buffer.sv
// Directed self-checking bench for row_pingpong_buffer with hand-computed expectations.
module tb_row_pingpong_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 80;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] raddr;
  logic              renable;
  logic [DATA_W-1:0] rdata;
  logic              rswap;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wbe;
  logic              wenable;
  logic              wcommit;
  logic              clr_flags;
  logic              back_full;
  logic              front_valid;
  logic              wovf;
  logic              rund;

  int checks = 0;
  int errors = 0;

  row_pingpong_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .renable(renable), .rdata(rdata),
    .rswap(rswap), .waddr(waddr), .wdata(wdata), .wbe(wbe), .wenable(wenable),
    .wcommit(wcommit), .clr_flags(clr_flags), .back_full(back_full),
    .front_valid(front_valid), .wovf(wovf), .rund(rund)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge, sample 1 ns later, then drop all strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    renable   = 1'b0;
    rswap     = 1'b0;
    wenable   = 1'b0;
    wcommit   = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic write_word(input int a, input logic [31:0] d, input logic [3:0] be);
    waddr   = ADDR_W'(a);
    wdata   = d;
    wbe     = be;
    wenable = 1'b1;
    tick();
  endtask

  task automatic read_word(input int a);
    raddr   = ADDR_W'(a);
    renable = 1'b1;
    tick();
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) write_word(i, base + 32'(i), 4'hF);
  endtask

  task automatic commit();
    wcommit = 1'b1;
    tick();
  endtask

  task automatic swap();
    rswap = 1'b1;
    tick();
  endtask

  task automatic clear();
    clr_flags = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; raddr = '0; renable = 1'b0; rswap = 1'b0; waddr = '0;
    wdata = '0; wbe = '0; wenable = 1'b0; wcommit = 1'b0; clr_flags = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_back_full", 32'(back_full), 32'h0);
    check("rst_front_valid", 32'(front_valid), 32'h0);
    check("rst_wovf", 32'(wovf), 32'h0);
    check("rst_rund", 32'(rund), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Basic fill of bank 1, commit, swap.
    fill(32'hA000_0000, DEPTH);
    commit();
    check("fill_back_full", 32'(back_full), 32'h1);
    swap();
    check("swap_back_full", 32'(back_full), 32'h0);
    check("swap_front_valid", 32'(front_valid), 32'h1);
    read_word(5);
    check("basic_read5", rdata, 32'hA000_0005);

    // Second row into bank 0 so both banks hold known data.
    fill(32'hB000_0000, DEPTH);
    commit();
    swap();
    read_word(5);
    check("row_b_read5", rdata, 32'hB000_0005);

    // Byte-enabled merge into the A row; out-of-range write ignored silently.
    write_word(3, 32'h1122_3344, 4'b0101);
    write_word(DEPTH, 32'hFFFF_FFFF, 4'hF);
    check("oob_write_no_wovf", 32'(wovf), 32'h0);
    commit();
    swap();
    read_word(3);
    check("be_merge_read3", rdata, 32'hA022_0044);
    read_word(4);
    check("be_untouched_read4", rdata, 32'hA000_0004);
    read_word(DEPTH);
    check("oob_read_zero", rdata, 32'h0);

    // Overrun: back (B row) committed, then a write and a second commit.
    commit();
    write_word(0, 32'hDEAD_BEEF, 4'hF);
    check("ovf_write_wovf", 32'(wovf), 32'h1);
    commit();
    check("ovf_commit_back_full", 32'(back_full), 32'h1);
    check("ovf_commit_wovf", 32'(wovf), 32'h1);
    clear();
    check("ovf_cleared", 32'(wovf), 32'h0);
    swap();
    read_word(0);
    check("ovf_data_kept", rdata, 32'hB000_0000);

    // Underrun repeats the current row; set beats same-cycle clear.
    swap();
    check("und_rund", 32'(rund), 32'h1);
    check("und_back_full", 32'(back_full), 32'h0);
    check("und_front_valid", 32'(front_valid), 32'h1);
    read_word(7);
    check("und_repeat_read7", rdata, 32'hB000_0007);
    rswap = 1'b1; clr_flags = 1'b1;
    tick();
    check("und_set_beats_clr", 32'(rund), 32'h1);
    clear();
    check("und_cleared", 32'(rund), 32'h0);

    // Commit + swap with back empty: commit applies, swap refused.
    wcommit = 1'b1; rswap = 1'b1;
    tick();
    check("sim0_back_full", 32'(back_full), 32'h1);
    check("sim0_rund", 32'(rund), 32'h1);
    check("sim0_wovf", 32'(wovf), 32'h0);
    read_word(7);
    check("sim0_no_swap_read7", rdata, 32'hB000_0007);
    clear();

    // Commit + swap with back full: swap happens, commit flagged and not applied.
    wcommit = 1'b1; rswap = 1'b1;
    tick();
    check("sim1_back_full", 32'(back_full), 32'h0);
    check("sim1_wovf", 32'(wovf), 32'h1);
    check("sim1_rund", 32'(rund), 32'h0);
    read_word(3);
    check("sim1_swapped_read3", rdata, 32'hA022_0044);
    clear();

    // Read + write + swap together: read sees old front, write is dropped.
    commit();
    rswap = 1'b1; renable = 1'b1; raddr = ADDR_W'(9);
    wenable = 1'b1; waddr = ADDR_W'(9); wdata = 32'h0; wbe = 4'hF;
    tick();
    check("rdswap_old_front", rdata, 32'hA000_0009);
    check("wrswap_wovf", 32'(wovf), 32'h1);
    check("wrswap_back_full", 32'(back_full), 32'h0);
    read_word(9);
    check("wrswap_dropped_read9", rdata, 32'hB000_0009);

    // Async reset in the middle of a partial row.
    fill(32'hC000_0000, 40);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rdata", rdata, 32'h0);
    check("arst_front_valid", 32'(front_valid), 32'h0);
    check("arst_wovf", 32'(wovf), 32'h0);
    check("arst_back_full", 32'(back_full), 32'h0);
    check("arst_rund", 32'(rund), 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_back_full", 32'(back_full), 32'h0);
    check("post_rst_front_valid", 32'(front_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
